// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the arbitrated N-input mux.
package mux_pkg;

  localparam int unsigned MAX_N     = 16;
  localparam int unsigned MAX_IDX_W = 4;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  // Index of the set bit in a one-hot vector (zero vector maps to 0).
  function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_N-1:0] oh);
    logic [MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (oh[i]) idx = idx | MAX_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mux_arb_arbiter.sv
// Combinational one-hot arbiter: lowest-index priority, optionally rotated to start at ptr.
module rr_arbiter #(
  parameter  int unsigned N     = 7,
  localparam int unsigned SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  input  logic             rr_en,
  output logic [N-1:0]     gnt
);

  logic [SEL_W-1:0] w_shift;
  logic [N-1:0]     w_rot;
  logic [N-1:0]     w_oh;

  // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    w_shift = rr_en ? ptr : '0;
    w_rot   = N'({req, req} >> w_shift);
    w_oh    = w_rot & (~w_rot + N'(1));
    gnt     = N'(({w_oh, w_oh} << w_shift) >> N);
  end

endmodule

// File: rtl/mux_arb.sv
// N-input valid/ready mux with internal arbitration and a one-entry registered output.
module mux_arb
  import mux_pkg::*;
#(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned N     = 7,
  parameter  int          RR    = 1,
  localparam int unsigned SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_sel,
  input  logic               out_ready
);

  localparam arb_mode_e MODE = (RR == 0) ? ARB_FIXED : ARB_RR;

  out_state_e       r_state;
  out_state_e       w_next;
  logic [WIDTH-1:0] r_data;
  logic [SEL_W-1:0] r_sel;
  logic [SEL_W-1:0] r_ptr;
  logic [N-1:0]     w_gnt;
  logic             w_load_en;
  logic             w_xfer;
  logic [WIDTH-1:0] w_sel_data;
  logic [SEL_W-1:0] w_idx;
  logic             w_rr_en;

  assign w_rr_en = (MODE == ARB_RR);

  rr_arbiter #(.N(N)) u_arb (
    .req   (in_valid),
    .ptr   (r_ptr),
    .rr_en (w_rr_en),
    .gnt   (w_gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_EMPTY;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_load_en) w_next = w_xfer ? ST_FULL : ST_EMPTY;
  end

  // Handshake decode; in_ready is forced low while reset is held.
  always_comb begin
    out_valid = (r_state == ST_FULL);
    w_load_en = !out_valid || out_ready;
    in_ready  = w_gnt & {N{w_load_en & rst_n}};
    w_xfer    = |in_ready;
  end

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < N; i++) begin
      w_sel_data = w_sel_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{w_gnt[i]}});
    end
    w_idx = SEL_W'(onehot_to_idx(MAX_N'(w_gnt)));
  end

  // Data, source index and RR pointer only move on a transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_sel  <= '0;
      r_ptr  <= '0;
    end else if (w_xfer) begin
      r_data <= w_sel_data;
      r_sel  <= w_idx;
      r_ptr  <= (w_idx == SEL_W'(N-1)) ? '0 : w_idx + SEL_W'(1);
    end
  end

  assign out_data = r_data;
  assign out_sel  = r_sel;

endmodule
